instr_fetch_unit: RTL and testbench

Instruction-fetch front end of the single-clock processor core: owns the program counter, drives the 12-bit word address into the synchronous imem, and captures the returned 32-bit instruction words. Fetched words and their PCs go into a 2-entry buffer that feeds decode over a valid/ready handshake. A one-cycle redirect port from execute (branch/jump) squashes the buffer and any in-flight read.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_skid_queue.sv | 51 +++++
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// the buffered {pc, instr} entry, the fetch FSM states and a small helper.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 12;
  localparam int unsigned FETCH_INSTR_W  = 32;
  localparam int unsigned FETCH_RESET_PC = 0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_FLUSHED = 1'b1
  } fetch_state_e;

  // Occupancy after one cycle of simultaneous push/pop.
  function automatic logic [1:0] next_count(input logic [1:0] count,
                                            input logic       push,
                                            input logic       pop);
    return count + {1'b0, push} - {1'b0, pop};
  endfunction

endpackage

// File: rtl/fetch_skid_queue.sv
// Two-entry FIFO between the imem capture stage and decode.
// Push and pop may occur in the same cycle; flush empties the queue.
// The caller guarantees no push into a full queue and no pop from empty.
module fetch_skid_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic       valid,
  output logic [1:0] count
);

  entry_t mem [2];
  logic   rd_ptr;
  logic   wr_ptr;

  // Storage, pointers and occupancy; flush wins over push/pop bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
      end
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= next_count(count, push, pop);
      end
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives the synchronous
// imem, captures returned words into a 2-entry queue and hands them to decode
// over valid/ready. A one-cycle redirect squashes the queue and any in-flight
// read. Optional macro FETCH_PERF_EN adds saturating perf_fetched and
// perf_bubbles counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned        INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_q,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic [ADDR_W-1:0]  fpc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         occupancy;
  logic [1:0]         q_count;
  logic               q_valid;
  entry_t             q_head;
  entry_t             q_push_data;

  assign pop         = q_valid & out_ready;
  assign push        = inflight & ~redirect_valid;
  assign q_push_data = '{pc: inflight_pc, instr: imem_q};

  // Words already buffered or in flight, net of this cycle's pop; counting
  // the in-flight read keeps the queue from ever being overrun.
  assign occupancy = {1'b0, q_count} + {2'b00, inflight} - {2'b00, pop};

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Next state and issue decision; redirect suppresses issue for its cycle.
  always_comb begin
    state_next = ST_RUN;
    issue      = 1'b0;
    if (redirect_valid) begin
      state_next = ST_FLUSHED;
    end else begin
      issue = (state == ST_FLUSHED) | (occupancy < 3'd2);
    end
  end

  // Fetch PC and the single outstanding imem read.
  always_ff @(posedge clock) begin
    if (reset) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fpc      <= redirect_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= fpc;
      fpc         <= fpc + ADDR_W'(1);
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_skid_queue #(
    .entry_t (entry_t)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (q_push_data),
    .pop       (pop),
    .head      (q_head),
    .valid     (q_valid),
    .count     (q_count)
  );

  assign imem_addr = fpc;
  assign out_valid = q_valid;
  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;

`ifdef FETCH_PERF_EN
  // Saturating counters of delivered instructions and decode-starved cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (out_ready && !q_valid && (perf_bubbles != '1)) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, back-pressure, redirects,
// PC wrap and mid-stream reset, against a behavioural synchronous imem.
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset;
  logic [11:0] imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [11:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_W   (12),
    .INSTR_W  (32),
    .RESET_PC (12'h000)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_q         (imem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction word stored at a given imem address.
  function automatic logic [31:0] word(input logic [11:0] a);
    return {20'hC0DE5, a};
  endfunction

  // Synchronous imem: data for the address presented in the previous cycle.
  initial imem_q = '0;
  always @(posedge clock) imem_q <= word(imem_addr);

  // The queue must never be pushed while full without a pop.
  always @(negedge clock) begin
    if (!reset) begin
      assert (!(dut.u_queue.push && !dut.u_queue.pop && dut.u_queue.count == 2'd2))
      else begin
        errors++;
        $error("FAIL overflow observed=push_into_full expected=no_overflow");
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic [11:0] pc);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"}, {20'd0, out_pc}, {20'd0, pc});
    check({tag, "_instr"}, out_instr, word(pc));
  endtask

  task automatic expect_idle(input string tag, input logic [11:0] addr);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_addr"}, {20'd0, imem_addr}, {20'd0, addr});
  endtask

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", {20'd0, out_pc}, 32'd0);
    check("rst_addr", {20'd0, imem_addr}, 32'd0);

    // Redirect while reset is held must be ignored.
    redirect_valid = 1'b1;
    redirect_pc    = 12'h055;
    tick();
    expect_idle("rst_redir", 12'h000);

    // Release: R0 issues 0, R1 captures, R2 presents pc 0.
    redirect_valid = 1'b0;
    reset          = 1'b0;
    out_ready      = 1'b1;
    tick();
    expect_idle("r1", 12'h001);
    tick();
    expect_head("r2", 12'h000);
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_head("stream", 12'(k));
    end

    // Back-pressure at pc 5 for four cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_head("hold", 12'h005);
      check("hold_addr", {20'd0, imem_addr}, 32'd7);
    end
    out_ready = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      tick();
      expect_head("release", 12'(k));
    end

    // Redirect coincident with the pop of pc 9.
    redirect_valid = 1'b1;
    redirect_pc    = 12'h100;
    tick();
    expect_idle("redir_t1", 12'h100);
    redirect_valid = 1'b0;
    tick();
    expect_idle("redir_t2", 12'h101);
    tick();
    expect_head("redir_t3", 12'h100);
    tick();
    expect_head("redir_t4", 12'h101);

    // Fill the queue, then redirect with it full.
    out_ready = 1'b0;
    tick();
    expect_head("full", 12'h101);
    check("full_addr", {20'd0, imem_addr}, 32'h103);
    redirect_valid = 1'b1;
    redirect_pc    = 12'h200;
    tick();
    expect_idle("fredir_t1", 12'h200);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    tick();
    expect_idle("fredir_t2", 12'h201);
    tick();
    expect_head("fredir_t3", 12'h200);
    tick();
    expect_head("fredir_t4", 12'h201);

    // PC wrap from 4095 to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 12'hFFE;
    tick();
    expect_idle("wrap_t1", 12'hFFE);
    redirect_valid = 1'b0;
    tick();
    expect_idle("wrap_t2", 12'hFFF);
    tick();
    expect_head("wrap_a", 12'hFFE);
    tick();
    expect_head("wrap_b", 12'hFFF);
    check("wrap_addr", {20'd0, imem_addr}, 32'd1);
    tick();
    expect_head("wrap_c", 12'h000);
    tick();
    expect_head("wrap_d", 12'h001);

    // Reset with the queue full.
    out_ready = 1'b0;
    tick();
    expect_head("pre_rst", 12'h001);
    check("pre_rst_addr", {20'd0, imem_addr}, 32'd3);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_addr", {20'd0, imem_addr}, 32'd0);
    check("mid_rst_pc", {20'd0, out_pc}, 32'd0);
    check("mid_rst_instr", out_instr, 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_fetched_rst", perf_fetched, 32'd0);
    check("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_idle("rr1", 12'h001);
    tick();
    expect_head("rr2", 12'h000);
`ifdef FETCH_PERF_EN
    check("perf_bubbles_r2", perf_bubbles, 32'd2);
    check("perf_fetched_r2", perf_fetched, 32'd0);
`endif
    tick();
    expect_head("rr3", 12'h001);
`ifdef FETCH_PERF_EN
    check("perf_fetched_1", perf_fetched, 32'd1);
`endif
    tick();
    expect_head("rr4", 12'h002);
`ifdef FETCH_PERF_EN
    check("perf_fetched_2", perf_fetched, 32'd2);
    check("perf_bubbles_end", perf_bubbles, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
